// File: rtl/irq_ctrl_if.sv
// Handshake between the interrupt controller and the CPU control unit.
// The controller side is the master: it raises the request and presents the vector.
interface irq_ctrl_if #(
  parameter int VEC_W = 10
);
  logic             int_req;
  logic             int_ack;
  logic             iret;
  logic [VEC_W-1:0] int_vec;
  logic [2:0]       int_id;
  logic             in_service;

  modport master (
    output int_req,
    output int_vec,
    output int_id,
    output in_service,
    input  int_ack,
    input  iret
  );

  modport slave (
    input  int_req,
    input  int_vec,
    input  int_id,
    input  in_service,
    output int_ack,
    output iret
  );
endinterface

// File: rtl/irq_ctrl.sv
// Prioritised, non-nesting interrupt controller: latches rising edges on the request lines,
// requests the control unit, and holds the in-service source until the matching return.
module irq_ctrl #(
  parameter int               NIRQ       = 4,
  parameter int               VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int               VEC_STRIDE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_in,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] mask,
  irq_ctrl_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t          state;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] id_onehot;
  logic [NIRQ-1:0] pending_next;
  logic [2:0]      int_id;
  logic            req_q;
  logic            svc_q;

  // Index 0 is the highest priority, so the lowest set bit wins.
  function automatic logic [2:0] lowest_index(input logic [NIRQ-1:0] v);
    lowest_index = 3'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = 3'(i);
    end
  endfunction

  assign rise      = irq & ~irq_q;
  assign eligible  = pending & mask;
  assign id_onehot = NIRQ'(1) << int_id;

  // A new edge on the acknowledged source re-arms it in the same cycle the ack clears it.
  always_comb begin
    pending_next = pending;
    if (state == REQ && bus.int_ack) begin
      pending_next = pending_next & ~id_onehot;
    end
    pending_next = pending_next | rise;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
      mask    <= '0;
      irq_q   <= '0;
      int_id  <= 3'd0;
      req_q   <= 1'b0;
      svc_q   <= 1'b0;
    end else begin
      irq_q   <= irq;
      pending <= pending_next;
      if (mask_we) begin
        mask <= mask_in;
      end
      case (state)
        IDLE: begin
          if (|eligible) begin
            state  <= REQ;
            int_id <= lowest_index(eligible);
            req_q  <= 1'b1;
          end
        end
        REQ: begin
          // The latched id is never preempted; only an ack or a mask withdrawal leaves REQ.
          if (bus.int_ack) begin
            state <= SERVICE;
            req_q <= 1'b0;
            svc_q <= 1'b1;
          end else if (!(|(mask & id_onehot))) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.iret) begin
            state <= IDLE;
            svc_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
          svc_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_req    = req_q;
  assign bus.in_service = svc_q;
  assign bus.int_id     = int_id;
  assign bus.int_vec    = VEC_BASE + VEC_W'(int_id) * VEC_W'(VEC_STRIDE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl, checked cycle by cycle against a
// behavioural model of the interrupt rules.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic [3:0] pending;
  logic [3:0] mask;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic [3:0] m_prev;
  logic       m_req;
  logic       m_svc;
  int         m_id;

  irq_ctrl_if #(.VEC_W(10)) bus ();

  irq_ctrl #(
    .NIRQ(4), .VEC_W(10), .VEC_BASE(10'h3C0), .VEC_STRIDE(4)
  ) dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .pending(pending), .mask(mask), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic [3:0] i, input logic we,
                           input logic [3:0] mi, input logic ack, input logic ret);
    logic [3:0] rise;
    logic [3:0] p_old;
    logic [3:0] k_old;
    int chosen;
    if (!r) begin
      m_pend = '0; m_mask = '0; m_prev = '0;
      m_req = 1'b0; m_svc = 1'b0; m_id = 0;
      return;
    end
    p_old = m_pend;
    k_old = m_mask;
    rise  = i & ~m_prev;
    if (m_req && ack) m_pend[m_id] = 1'b0;
    m_pend = m_pend | rise;
    if (m_req) begin
      if (ack) begin
        m_req = 1'b0;
        m_svc = 1'b1;
      end else if (!k_old[m_id]) begin
        m_req = 1'b0;
      end
    end else if (m_svc) begin
      if (ret) m_svc = 1'b0;
    end else if ((p_old & k_old) != 4'b0) begin
      chosen = 0;
      for (int s = 0; s < 4; s++) begin
        if (p_old[s] && k_old[s]) begin
          chosen = s;
          break;
        end
      end
      m_req = 1'b1;
      m_id  = chosen;
    end
    if (we) m_mask = mi;
    m_prev = i;
  endtask

  task automatic compareModel();
    checkOutput("int_req",    32'(bus.int_req),    32'(m_req));
    checkOutput("in_service", 32'(bus.in_service), 32'(m_svc));
    checkOutput("int_id",     32'(bus.int_id),     32'(m_id));
    checkOutput("int_vec",    32'(bus.int_vec),    (32'h3C0 + 32'(m_id) * 4) & 32'h3FF);
    checkOutput("pending",    32'(pending),        32'(m_pend));
    checkOutput("mask",       32'(mask),           32'(m_mask));
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] i, input logic we,
                               input logic [3:0] mi, input logic ack, input logic ret);
    @(negedge clk);
    reset       = r;
    irq         = i;
    mask_we     = we;
    mask_in     = mi;
    bus.int_ack = ack;
    bus.iret    = ret;
    @(posedge clk);
    modelStep(r, i, we, mi, ack, ret);
    #1;
    compareModel();
  endtask

  initial begin
    logic [3:0] cur_irq;
    reset = 1'b0; irq = 4'h0; mask_we = 1'b0; mask_in = 4'h0;
    bus.int_ack = 1'b0; bus.iret = 1'b0;

    // Reset held with all lines high, then released with mask still zero
    applyStimulus(0, 4'hF, 0, 4'h0, 0, 0);
    applyStimulus(0, 4'hF, 0, 4'h0, 0, 0);
    checkOutput("t1_vec", 32'(bus.int_vec), 32'h3C0);
    checkOutput("t1_pend", 32'(pending), 32'h0);
    applyStimulus(1, 4'hF, 0, 4'h0, 0, 0);
    checkOutput("t1_pend_rel", 32'(pending), 32'hF);
    applyStimulus(1, 4'hF, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'hF, 0, 4'h0, 0, 0);
    checkOutput("t1_noreq", 32'(bus.int_req), 32'h0);

    // Single source
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 1, 4'hF, 0, 0);
    applyStimulus(1, 4'h4, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    checkOutput("t2_req", 32'(bus.int_req), 32'h1);
    checkOutput("t2_vec", 32'(bus.int_vec), 32'h3C8);
    applyStimulus(1, 4'h0, 0, 4'h0, 1, 0);
    checkOutput("t2_svc", 32'(bus.in_service), 32'h1);
    checkOutput("t2_pend", 32'(pending), 32'h0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);
    checkOutput("t2_idle", 32'(bus.int_req), 32'h0);

    // Priority between simultaneous edges
    applyStimulus(1, 4'hA, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    checkOutput("t3_vec1", 32'(bus.int_vec), 32'h3C4);
    applyStimulus(1, 4'h0, 0, 4'h0, 1, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    checkOutput("t3_vec3", 32'(bus.int_vec), 32'h3CC);
    applyStimulus(1, 4'h0, 0, 4'h0, 1, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);

    // No preemption in REQ, no nesting in SERVICE
    applyStimulus(1, 4'h4, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h1, 0, 4'h0, 0, 0);
    checkOutput("t4_hold", 32'(bus.int_id), 32'h2);
    applyStimulus(1, 4'h0, 0, 4'h0, 1, 0);
    checkOutput("t4_nonest", 32'(bus.int_req), 32'h0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    checkOutput("t4_id0", 32'(bus.int_id), 32'h0);
    applyStimulus(1, 4'h0, 0, 4'h0, 1, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);

    // Set wins over clear on the acknowledged source
    applyStimulus(1, 4'h4, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h4, 0, 4'h0, 1, 0);
    checkOutput("setwins", 32'(pending), 32'h4);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 1, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);

    // Withdraw by masking the requested source
    applyStimulus(1, 4'hA, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 1, 4'hD, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    checkOutput("t5_drop", 32'(bus.int_req), 32'h0);
    checkOutput("t5_kept", 32'(pending), 32'hA);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    checkOutput("t5_id3", 32'(bus.int_id), 32'h3);
    applyStimulus(1, 4'h0, 1, 4'hF, 1, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    checkOutput("t5_id1", 32'(bus.int_id), 32'h1);
    applyStimulus(1, 4'h0, 0, 4'h0, 1, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);

    // Reset in the middle of a handler, then a stray iret
    applyStimulus(1, 4'h1, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
    applyStimulus(1, 4'h0, 0, 4'h0, 1, 0);
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
    checkOutput("t6_svc", 32'(bus.in_service), 32'h0);
    checkOutput("t6_mask", 32'(mask), 32'h0);
    applyStimulus(1, 4'h0, 0, 4'h0, 0, 1);
    checkOutput("t6_stray", 32'(bus.in_service), 32'h0);

    // Random traffic
    cur_irq = 4'h0;
    applyStimulus(1, cur_irq, 1, 4'hF, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) cur_irq = cur_irq ^ 4'($urandom);
      applyStimulus(($urandom_range(0, 99) != 0), cur_irq,
                    ($urandom_range(0, 9) == 0), 4'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
